// File: rtl/scroll_hv_pos_gen_pkg.sv
// Shared constants for the scroll/position front end: CPU register map and bus widths.
package scroll_hv_pos_gen_pkg;

   localparam int unsigned CPU_AW = 2;
   localparam int unsigned CPU_DW = 8;

   localparam logic [CPU_AW-1:0] SCR_XL = 2'd0;
   localparam logic [CPU_AW-1:0] SCR_XH = 2'd1;
   localparam logic [CPU_AW-1:0] SCR_YL = 2'd2;
   localparam logic [CPU_AW-1:0] SCR_YH = 2'd3;

endpackage

// File: rtl/scroll_nibble_adder.sv
// 4-bit carry-lookahead slice: sum_c/cout_c = a_i + b_i + cin_i, purely combinational.
module scroll_nibble_adder (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_c,
   output logic       cout_c
);

   logic [3:0] p;
   logic [3:0] g;
   logic [4:0] c;

   assign p = a_i ^ b_i;
   assign g = a_i & b_i;

   assign c[0] = cin_i;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c[0]);

   assign sum_c  = p ^ c[3:0];
   assign cout_c = c[4];

endmodule

// File: rtl/scroll_hv_pos_gen.sv
// Pixel H/V timing with blanking, double-buffered CPU scroll registers and
// registered scrolled coordinates built from rippled 4-bit adder slices.
module scroll_hv_pos_gen
   import scroll_hv_pos_gen_pkg::*;
#(
   parameter int unsigned CW        = 9,
   parameter int unsigned SW        = 9,
   parameter int unsigned H_TOTAL   = 384,
   parameter int unsigned HBL_START = 256,
   parameter int unsigned V_TOTAL   = 264,
   parameter int unsigned VBL_START = 224
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              ce_pix,
   input  logic              cpu_wr,
   input  logic [CPU_AW-1:0] cpu_addr,
   input  logic [CPU_DW-1:0] cpu_din,
   output logic [CW-1:0]     h_cnt,
   output logic [CW-1:0]     v_cnt,
   output logic              hblank,
   output logic              vblank,
   output logic              frame_ld,
   output logic [SW-1:0]     scr_x,
   output logic [SW-1:0]     scr_y,
   output logic              scr_x_c,
   output logic              scr_y_c
);

   localparam int unsigned NSL = (SW + 3) / 4;
   localparam int unsigned PW  = NSL * 4;

   logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [CW-1:0] h_nxt, v_nxt;
   logic          h_last, v_last, xfer;
   logic          hblank_q, hblank_d, vblank_q, vblank_d;
   logic          frame_ld_q, frame_ld_d;
   logic [SW-1:0] shadow_x_q, shadow_x_d, shadow_y_q, shadow_y_d;
   logic [SW-1:0] act_x_q, act_x_d, act_y_q, act_y_d;
   logic [SW-1:0] scr_x_q, scr_x_d, scr_y_q, scr_y_d;
   logic          scr_xc_q, scr_xc_d, scr_yc_q, scr_yc_d;

   logic [PW-1:0] ax_pad, bx_pad, sx_pad;
   logic [PW-1:0] ay_pad, by_pad, sy_pad;
   logic [NSL:0]  cx, cy;
   logic [SW-1:0] sum_x, sum_y;
   logic          carry_x, carry_y;
   logic          unused_ok;

   // Operands zero-padded to whole slices; padding bits of the last slice stay 0.
   assign ax_pad = PW'(h_cnt_q);
   assign bx_pad = PW'(act_x_q);
   assign ay_pad = PW'(v_cnt_q);
   assign by_pad = PW'(act_y_q);
   assign cx[0]  = 1'b0;
   assign cy[0]  = 1'b0;

   genvar gi;
   for (gi = 0; gi < NSL; gi++) begin : g_slice
      scroll_nibble_adder u_add_x (
         .a_i    (ax_pad[4*gi +: 4]),
         .b_i    (bx_pad[4*gi +: 4]),
         .cin_i  (cx[gi]),
         .sum_c  (sx_pad[4*gi +: 4]),
         .cout_c (cx[gi+1])
      );
      scroll_nibble_adder u_add_y (
         .a_i    (ay_pad[4*gi +: 4]),
         .b_i    (by_pad[4*gi +: 4]),
         .cin_i  (cy[gi]),
         .sum_c  (sy_pad[4*gi +: 4]),
         .cout_c (cy[gi+1])
      );
   end

   // With a partial last slice the true carry lands on bit SW of the padded sum.
   if ((SW % 4) != 0) begin : g_carry_bit
      assign carry_x = sx_pad[SW];
      assign carry_y = sy_pad[SW];
   end else begin : g_carry_slice
      assign carry_x = cx[NSL];
      assign carry_y = cy[NSL];
   end

   assign sum_x     = sx_pad[SW-1:0];
   assign sum_y     = sy_pad[SW-1:0];
   assign unused_ok = ^{sx_pad, sy_pad, cx, cy};

   always_comb begin
      h_cnt_d    = h_cnt_q;
      v_cnt_d    = v_cnt_q;
      hblank_d   = hblank_q;
      vblank_d   = vblank_q;
      frame_ld_d = 1'b0;
      shadow_x_d = shadow_x_q;
      shadow_y_d = shadow_y_q;
      act_x_d    = act_x_q;
      act_y_d    = act_y_q;
      scr_x_d    = scr_x_q;
      scr_y_d    = scr_y_q;
      scr_xc_d   = scr_xc_q;
      scr_yc_d   = scr_yc_q;

      h_last = (h_cnt_q == CW'(H_TOTAL - 1));
      v_last = (v_cnt_q == CW'(V_TOTAL - 1));
      h_nxt  = h_last ? '0 : h_cnt_q + CW'(1);
      v_nxt  = v_cnt_q;
      if (h_last) begin
         v_nxt = v_last ? '0 : v_cnt_q + CW'(1);
      end
      xfer = h_last && (v_nxt == CW'(VBL_START));

      if (ce_pix) begin
         h_cnt_d    = h_nxt;
         v_cnt_d    = v_nxt;
         hblank_d   = (h_nxt >= CW'(HBL_START));
         vblank_d   = (v_nxt >= CW'(VBL_START));
         frame_ld_d = xfer;
         scr_x_d    = sum_x;
         scr_y_d    = sum_y;
         scr_xc_d   = carry_x;
         scr_yc_d   = carry_y;
         if (xfer) begin
            act_x_d = shadow_x_q;
            act_y_d = shadow_y_q;
         end
      end

      // Shadow writes are ungated; a transfer in the same Clk already saw the old value.
      if (cpu_wr) begin
         case (cpu_addr)
            SCR_XL:  shadow_x_d[7:0] = cpu_din;
            SCR_XH:  shadow_x_d[8]   = cpu_din[0];
            SCR_YL:  shadow_y_d[7:0] = cpu_din;
            default: shadow_y_d[8]   = cpu_din[0];
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         h_cnt_q    <= '0;
         v_cnt_q    <= '0;
         hblank_q   <= 1'b0;
         vblank_q   <= 1'b0;
         frame_ld_q <= 1'b0;
         shadow_x_q <= '0;
         shadow_y_q <= '0;
         act_x_q    <= '0;
         act_y_q    <= '0;
         scr_x_q    <= '0;
         scr_y_q    <= '0;
         scr_xc_q   <= 1'b0;
         scr_yc_q   <= 1'b0;
      end else begin
         h_cnt_q    <= h_cnt_d;
         v_cnt_q    <= v_cnt_d;
         hblank_q   <= hblank_d;
         vblank_q   <= vblank_d;
         frame_ld_q <= frame_ld_d;
         shadow_x_q <= shadow_x_d;
         shadow_y_q <= shadow_y_d;
         act_x_q    <= act_x_d;
         act_y_q    <= act_y_d;
         scr_x_q    <= scr_x_d;
         scr_y_q    <= scr_y_d;
         scr_xc_q   <= scr_xc_d;
         scr_yc_q   <= scr_yc_d;
      end
   end

   assign h_cnt    = h_cnt_q;
   assign v_cnt    = v_cnt_q;
   assign hblank   = hblank_q;
   assign vblank   = vblank_q;
   assign frame_ld = frame_ld_q;
   assign scr_x    = scr_x_q;
   assign scr_y    = scr_y_q;
   assign scr_x_c  = scr_xc_q;
   assign scr_y_c  = scr_yc_q;

endmodule

// File: tb/tb_scroll_hv_pos_gen.sv
// Bench for scroll_hv_pos_gen: frame-position model checked every Clk plus directed literal checks.
// A short frame (10 lines) keeps runtime small; line width and hblank match the real timing.
module tb_scroll_hv_pos_gen;
   import scroll_hv_pos_gen_pkg::*;

   localparam int unsigned CW  = 9;
   localparam int unsigned SW  = 9;
   localparam int unsigned H_T = 384;
   localparam int unsigned HBL = 256;
   localparam int unsigned V_T = 10;
   localparam int unsigned VBL = 7;
   localparam int          FR  = H_T * V_T;
   localparam int          MODV = 1 << SW;
   localparam int          BUDGET = 8000;

   logic          clk = 1'b0;
   logic          rst_n, ce, wr;
   logic [1:0]    addr;
   logic [7:0]    din;
   logic [CW-1:0] h_cnt, v_cnt;
   logic          hblank, vblank, frame_ld;
   logic [SW-1:0] scr_x, scr_y;
   logic          scr_x_c, scr_y_c;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   scroll_hv_pos_gen #(
      .CW(CW), .SW(SW), .H_TOTAL(H_T), .HBL_START(HBL), .V_TOTAL(V_T), .VBL_START(VBL)
   ) dut (
      .Clk(clk), .Reset_n(rst_n), .ce_pix(ce), .cpu_wr(wr), .cpu_addr(addr), .cpu_din(din),
      .h_cnt(h_cnt), .v_cnt(v_cnt), .hblank(hblank), .vblank(vblank), .frame_ld(frame_ld),
      .scr_x(scr_x), .scr_y(scr_y), .scr_x_c(scr_x_c), .scr_y_c(scr_y_c)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: frame position as a single pixel index; scroll math in plain integers.
   bit m_on = 1'b0;
   int m_pos, m_ax, m_ay, m_shx, m_shy, m_sx, m_sy, m_cx, m_cy, m_fl;
   int s_r, s_ce, s_wr, s_a, s_d, oh, ov, tx, ty;

   always begin
      @(posedge clk);
      s_r = int'(rst_n); s_ce = int'(ce); s_wr = int'(wr); s_a = int'(addr); s_d = int'(din);
      #1;
      if (s_r == 0) begin
         m_on = 1'b1;
         m_pos = 0; m_ax = 0; m_ay = 0; m_shx = 0; m_shy = 0;
         m_sx = 0; m_sy = 0; m_cx = 0; m_cy = 0; m_fl = 0;
      end else if (m_on) begin
         oh = m_pos % H_T;
         ov = m_pos / H_T;
         m_fl = 0;
         if (s_ce != 0) begin
            tx = oh + m_ax;
            ty = ov + m_ay;
            m_sx = tx % MODV; m_cx = tx / MODV;
            m_sy = ty % MODV; m_cy = ty / MODV;
            m_pos = (m_pos + 1) % FR;
            if (m_pos == VBL * H_T) begin
               m_fl = 1;
               m_ax = m_shx;
               m_ay = m_shy;
            end
         end
         if (s_wr != 0) begin
            case (s_a)
               0: m_shx = (m_shx & 'h100) | s_d;
               1: m_shx = (m_shx & 'h0FF) | ((s_d & 1) << 8);
               2: m_shy = (m_shy & 'h100) | s_d;
               default: m_shy = (m_shy & 'h0FF) | ((s_d & 1) << 8);
            endcase
         end
      end
      if (m_on) begin
         chk("model_h", 32'(h_cnt), 32'(m_pos % H_T));
         chk("model_v", 32'(v_cnt), 32'(m_pos / H_T));
         chk("model_hblank", 32'(hblank), 32'((m_pos % H_T) >= HBL));
         chk("model_vblank", 32'(vblank), 32'((m_pos / H_T) >= VBL));
         chk("model_frame_ld", 32'(frame_ld), 32'(m_fl));
         chk("model_scr_x", 32'(scr_x), 32'(m_sx));
         chk("model_scr_y", 32'(scr_y), 32'(m_sy));
         chk("model_scr_x_c", 32'(scr_x_c), 32'(m_cx));
         chk("model_scr_y_c", 32'(scr_y_c), 32'(m_cy));
      end
   end

   task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
      wr = 1'b1; addr = a; din = d;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic wait_hv(input int h, input int v);
      int n = 0;
      while (!(int'(h_cnt) == h && int'(v_cnt) == v) && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      chk("wait_hv_reached", 32'(int'(h_cnt) == h && int'(v_cnt) == v), 32'd1);
   endtask

   task automatic wait_fl();
      int n = 0;
      while (frame_ld !== 1'b1 && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      chk("wait_frame_ld", 32'(frame_ld), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; ce = 1'b1; wr = 1'b0; addr = '0; din = '0;
      repeat (3) @(negedge clk);
      chk("rst_h", 32'(h_cnt), 0);
      chk("rst_v", 32'(v_cnt), 0);
      chk("rst_scr_x", 32'(scr_x), 0);
      chk("rst_scr_y", 32'(scr_y), 0);
      chk("rst_blank", 32'({hblank, vblank, frame_ld, scr_x_c, scr_y_c}), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("first_h", 32'(h_cnt), 1);

      // Mid-frame shadow write must not disturb the live sum.
      cpu_write(SCR_XL, 8'hFF);
      cpu_write(SCR_XH, 8'h01);
      chk("dbuf_hold", 32'(scr_x), 2);

      wait_hv(HBL - 1, 0);
      chk("hblank_before", 32'(hblank), 0);
      @(negedge clk);
      chk("hblank_at", 32'(hblank), 1);

      wait_fl();
      chk("xfer_h", 32'(h_cnt), 0);
      chk("xfer_v", 32'(v_cnt), VBL);
      chk("xfer_vblank", 32'(vblank), 1);
      chk("xfer_scr_x_old", 32'(scr_x), H_T - 1);
      @(negedge clk);
      chk("dbuf_new_x", 32'(scr_x), 'h1FF);
      @(negedge clk);
      chk("x_wrap_sum", 32'(scr_x), 0);
      chk("x_wrap_carry", 32'(scr_x_c), 1);

      cpu_write(SCR_YL, 8'h20);
      cpu_write(SCR_YH, 8'h00);
      cpu_write(SCR_XL, 8'hFE);

      wait_hv(H_T - 1, V_T - 1);
      @(negedge clk);
      chk("wrap_h", 32'(h_cnt), 0);
      chk("wrap_v", 32'(v_cnt), 0);
      chk("wrap_blanks", 32'({hblank, vblank}), 0);

      // Write landing on the transfer Clk goes to shadow only.
      wait_hv(H_T - 1, VBL - 1);
      cpu_write(SCR_YL, 8'h10);
      chk("coll_frame_ld", 32'(frame_ld), 1);
      @(negedge clk);
      chk("coll_scr_y", 32'(scr_y), VBL + 'h20);
      chk("coll_scr_x", 32'(scr_x), 'h1FE);

      wait_hv(6, VBL);
      chk("sum_wrap_x", 32'(scr_x), 'h003);
      chk("sum_wrap_c", 32'(scr_x_c), 1);

      wait_hv(100, VBL + 1);
      ce = 1'b0;
      repeat (4) @(negedge clk);
      cpu_write(SCR_XL, 8'h55);
      repeat (5) @(negedge clk);
      chk("gate_h", 32'(h_cnt), 100);
      chk("gate_v", 32'(v_cnt), VBL + 1);
      chk("gate_scr_x", 32'(scr_x), 'h061);
      chk("gate_scr_x_c", 32'(scr_x_c), 1);
      chk("gate_scr_y", 32'(scr_y), VBL + 1 + 'h20);
      ce = 1'b1;

      wait_fl();
      @(negedge clk);
      chk("next_frame_y", 32'(scr_y), VBL + 'h10);
      chk("next_frame_x", 32'(scr_x), 'h155);
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
